// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor, carry chain split into STAGES segments.
// Latency: STAGES cycles from acceptance to out_valid; one beat per cycle.
// Backpressure: out_valid && !out_ready freezes every stage; in_ready = !stall.
module addsub_pipe #(
  parameter int WIDTH    = 32,
  parameter int STAGES   = 4,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;
  localparam int MSB  = WIDTH - 1;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Per-stage state. Operands travel full width so that later stages can pick
  // their slice, and the top bits survive to the end for the overflow test.
  // r_b holds B already inverted for subtraction.
  logic [STAGES-1:0]            r_vld;
  logic [STAGES-1:0]            r_c;
  logic [STAGES-1:0]            r_sub;
  logic [STAGES-1:0][WIDTH-1:0] r_a;
  logic [STAGES-1:0][WIDTH-1:0] r_b;
  logic [STAGES-1:0][WIDTH-1:0] r_res;

  // Stage inputs (what each stage sees before its edge) and stage results.
  logic [STAGES-1:0][WIDTH-1:0] w_ain;
  logic [STAGES-1:0][WIDTH-1:0] w_bin;
  logic [STAGES-1:0][WIDTH-1:0] w_rin;
  logic [STAGES-1:0][WIDTH-1:0] w_rout;
  logic [STAGES-1:0]            w_cin;
  logic [STAGES-1:0]            w_vin;
  logic [STAGES-1:0]            w_sin;
  logic [STAGES-1:0]            w_cout;
  logic [STAGES-1:0][SEG:0]     w_sum;

  logic             w_stall;
  logic [WIDTH-1:0] w_raw;
  logic             w_amsb;
  logic             w_bmsb;
  logic             w_unused;

  assign w_stall   = r_vld[LAST] & ~out_ready;
  assign in_ready  = ~w_stall;
  assign out_valid = r_vld[LAST];

  // Route each stage's inputs and add its SEG-bit slice with the incoming carry.
  always_comb begin
    w_ain  = '0;
    w_bin  = '0;
    w_rin  = '0;
    w_rout = '0;
    w_cin  = '0;
    w_vin  = '0;
    w_sin  = '0;
    w_cout = '0;
    w_sum  = '0;
    // Stage 0 takes the raw beat; the +1 of two's-complement negate enters as carry-in.
    w_ain[0] = a;
    w_bin[0] = b ^ {WIDTH{sub}};
    w_rin[0] = '0;
    w_cin[0] = sub;
    w_sin[0] = sub;
    w_vin[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      w_ain[k] = r_a[k-1];
      w_bin[k] = r_b[k-1];
      w_rin[k] = r_res[k-1];
      w_cin[k] = r_c[k-1];
      w_sin[k] = r_sub[k-1];
      w_vin[k] = r_vld[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_sum[k] = {1'b0, w_ain[k][k*SEG +: SEG]}
               + {1'b0, w_bin[k][k*SEG +: SEG]}
               + {{SEG{1'b0}}, w_cin[k]};
      w_rout[k] = w_rin[k];
      w_rout[k][k*SEG +: SEG] = w_sum[k][SEG-1:0];
      w_cout[k] = w_sum[k][SEG];
    end
  end

  // Advance the whole pipe in lockstep unless the output is stalled; reset flushes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_c   <= '0;
      r_sub <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
    end else if (!w_stall) begin
      r_vld <= w_vin;
      r_c   <= w_cout;
      r_sub <= w_sin;
      r_a   <= w_ain;
      r_b   <= w_bin;
      r_res <= w_rout;
    end
  end

  // Final stage: flags from the completed raw sum; the top carry only feeds cout.
  assign w_raw  = r_res[LAST];
  assign w_amsb = r_a[LAST][MSB];
  assign w_bmsb = r_b[LAST][MSB];
  assign ovf    = (w_amsb == w_bmsb) && (w_raw[MSB] != w_amsb);
  assign cout   = r_c[LAST] ^ r_sub[LAST];
  assign result = ((SATURATE != 0) && ovf) ? (w_amsb ? SMIN : SMAX) : w_raw;

  // Low operand bits in the last stage are already consumed.
  assign w_unused = ^{r_a[LAST], r_b[LAST]};

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe: four instances (S4 wrap, S4 saturate, S1, S32)
// share stimulus; each has its own scoreboard driven by its own handshake.
module tb_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  always #5 clk = ~clk;

  logic        ov [4];
  logic        ir [4];
  logic        co [4];
  logic        of [4];
  logic [31:0] res [4];

  localparam int STG  [4] = '{4, 4, 1, 32};
  localparam bit SATP [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  addsub_pipe #(.WIDTH(32), .STAGES(4), .SATURATE(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b), .sub(sub),
    .out_valid(ov[0]), .out_ready(out_ready), .result(res[0]), .cout(co[0]), .ovf(of[0]));
  addsub_pipe #(.WIDTH(32), .STAGES(4), .SATURATE(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b), .sub(sub),
    .out_valid(ov[1]), .out_ready(out_ready), .result(res[1]), .cout(co[1]), .ovf(of[1]));
  addsub_pipe #(.WIDTH(32), .STAGES(1), .SATURATE(0)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b), .sub(sub),
    .out_valid(ov[2]), .out_ready(out_ready), .result(res[2]), .cout(co[2]), .ovf(of[2]));
  addsub_pipe #(.WIDTH(32), .STAGES(32), .SATURATE(0)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .a(a), .b(b), .sub(sub),
    .out_valid(ov[3]), .out_ready(out_ready), .result(res[3]), .cout(co[3]), .ovf(of[3]));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int i, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s dut%0d got %0h want %0h", nm, i, got, want);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic. Returns {cout, ovf, result}.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic s, input bit sat);
    longint sx, sy, r;
    longint unsigned ux, uy;
    logic c, v;
    logic [31:0] q;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    r  = s ? (sx - sy) : (sx + sy);
    c  = s ? (x < y) : ((ux + uy) > 64'h0000_0000_FFFF_FFFF);
    v  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    q  = r[31:0];
    if (sat && v) q = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    return {c, v, q};
  endfunction

  // Scoreboards: ring buffers of accepted beats with acceptance edge and stall count.
  logic [31:0] qa  [4][128];
  logic [31:0] qb  [4][128];
  logic        qs  [4][128];
  int          qe  [4][128];
  int          qst [4][128];
  int          hd [4] = '{0, 0, 0, 0};
  int          tl [4] = '{0, 0, 0, 0};
  int          stall_cnt [4] = '{0, 0, 0, 0};
  int          edge_no = 0;
  bit          run = 1'b0;
  bit          pinned = 1'b0;
  bit          prev_rst = 1'b1;
  bit          drain_req = 1'b0;
  bit          drain_done = 1'b0;

  always @(posedge clk) edge_no <= edge_no + 1;

  // Single compare process, sampling on the falling edge.
  always @(negedge clk) begin : mon
    int h;
    logic [33:0] e;
    if (run) begin
      if (!pinned) begin
        pinned = 1'b1;
        chk("pin_add_carry", 0, model(32'h0000_FFFF, 32'h1, 1'b0, 1'b0), {2'b00, 32'h0001_0000});
        chk("pin_sub_borrow", 0, model(32'h3, 32'h5, 1'b1, 1'b0), {2'b10, 32'hFFFF_FFFE});
        chk("pin_ovf_wrap", 0, model(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0), {2'b01, 32'h8000_0000});
        chk("pin_ovf_sat", 1, model(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1), {2'b01, 32'h7FFF_FFFF});
        chk("pin_neg_sat", 1, model(32'h8000_0000, 32'h1, 1'b1, 1'b1), {2'b01, 32'h8000_0000});
        chk("pin_full_carry", 2, model(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0), {2'b10, 32'h0});
      end
      for (int i = 0; i < 4; i++) begin
        chk("in_ready", i, ir[i], !(ov[i] && !out_ready));
        if (prev_rst) chk("post_reset", i, {ov[i], co[i], of[i], res[i]}, 64'h0);
        if (rst) begin
          hd[i] = 0;
          tl[i] = 0;
        end else begin
          if (ov[i]) begin
            if (hd[i] == tl[i]) begin
              n_cmp++;
              n_err++;
              $display("FAIL spurious_beat dut%0d got result %h want no beat", i, res[i]);
            end else begin
              h = hd[i] % 128;
              e = model(qa[i][h], qb[i][h], qs[i][h], SATP[i]);
              chk("data", i, {co[i], of[i], res[i]}, e);
              if (out_ready) begin
                chk("latency", i, edge_no + 1, qe[i][h] + STG[i] + (stall_cnt[i] - qst[i][h]));
                hd[i]++;
              end
            end
          end
          if (in_valid && ir[i]) begin
            h = tl[i] % 128;
            qa[i][h]  = a;
            qb[i][h]  = b;
            qs[i][h]  = sub;
            qe[i][h]  = edge_no + 1;
            qst[i][h] = stall_cnt[i];
            tl[i]++;
          end
          if (ov[i] && !out_ready) stall_cnt[i]++;
        end
      end
      prev_rst = rst;
      if (drain_req && !drain_done) begin
        for (int i = 0; i < 4; i++) chk("drain_empty", i, tl[i] - hd[i], 64'h0);
        drain_done = 1'b1;
      end
    end
  end

  // One cycle of stimulus; acc reports whether instance 0 takes the beat.
  task automatic cyc(input logic r, input logic v, input logic [31:0] aa, input logic [31:0] bb,
                     input logic s, input logic rdy, output logic acc);
    rst = r; in_valid = v; a = aa; b = bb; sub = s; out_ready = rdy;
    @(negedge clk);
    acc = v && ir[0];
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rv();
    case ($urandom % 6)
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin : drv
    logic acc;
    int idx;
    int bub [6];
    bub = '{1, 0, 1, 1, 0, 1};
    @(posedge clk);
    #1;
    run = 1'b1;
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);

    // Directed vectors from the test plan, back to back.
    cyc(1'b0, 1'b1, 32'h0000_FFFF, 32'h1, 1'b0, 1'b1, acc);
    cyc(1'b0, 1'b1, 32'h3, 32'h5, 1'b1, 1'b1, acc);
    cyc(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, acc);
    cyc(1'b0, 1'b1, 32'h8000_0000, 32'h1, 1'b1, 1'b1, acc);
    cyc(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, acc);
    repeat (40) cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);

    // Bubble pattern at full throughput.
    for (int k = 0; k < 6; k++) cyc(1'b0, bub[k] != 0, $urandom, $urandom, 1'b0, 1'b1, acc);
    repeat (40) cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);

    // Backpressure: 8 beats a=b=i, alternating sub, out_ready low for cycles 5-8.
    idx = 0;
    for (int c = 1; c <= 30; c++) begin
      if (idx < 8) cyc(1'b0, 1'b1, idx, idx, idx[0], !(c >= 5 && c <= 8), acc);
      else         cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, !(c >= 5 && c <= 8), acc);
      if (acc) idx++;
    end
    repeat (40) cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);

    // Reset with three beats in flight, then one fresh beat.
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 32'h100 + k, 32'h5, 1'b0, 1'b1, acc);
    cyc(1'b1, 1'b1, 32'h1234, 32'h1, 1'b0, 1'b1, acc);
    cyc(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, acc);
    repeat (40) cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);

    // Randomized traffic with random backpressure and rare resets.
    for (int n = 0; n < 3000; n++)
      cyc(($urandom % 400) == 0, ($urandom % 10) < 7, rv(), rv(), $urandom % 2,
          ($urandom % 10) < 7, acc);

    repeat (40) cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
    drain_req = 1'b1;
    @(negedge clk);
    #1;
    if (!drain_done) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_check got not_run want run");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined two's-complement adder/subtractor.
- Splits a WIDTH-bit carry chain into STAGES segments with one segment per pipeline stage.
- Carries a per-operation add/subtract select, a saturation option and signed-overflow and borrow flags, under a valid/ready handshake.
- Sits between the CORDIC iteration datapath and the ALU, so that wide X/Y/Z updates meet timing at full throughput.

Parameters:
- WIDTH, 32, operand and result width in bits; WIDTH >= 2 and WIDTH % STAGES == 0.
- STAGES, 4, number of pipeline stages (carry-chain segments); 1 <= STAGES <= WIDTH.
- SATURATE, 0, 1 = clamp signed overflow to the signed max/min; 0 = wrap.

Ports:
- clk        in   1      clock; all state updates on the rising edge
- rst        in   1      synchronous, active-high reset
- in_valid   in   1      operand beat valid
- in_ready   out  1      block can accept a beat this cycle
- a          in   WIDTH  operand A
- b          in   WIDTH  operand B
- sub        in   1      0: a+b; 1: a-b
- out_valid  out  1      result beat valid
- out_ready  in   1      downstream accepts the result
- result     out  WIDTH  sum or difference, wrapped or saturated
- cout       out  1      add: carry-out; sub: borrow (1 when a < b unsigned)
- ovf        out  1      signed overflow of the unsaturated result

Behaviour:
- Arithmetic:
  - Computes a + (b XOR {WIDTH{sub}}) + sub.
  - cout = final_carry XOR sub.
  - ovf = (a[MSB] == b_eff[MSB]) && (raw[MSB] != a[MSB]), where b_eff is the inverted B when sub=1.
- Saturation:
  - SATURATE=1 and ovf=1: result = a[MSB] ? {1'b1, {WIDTH-1{0}}} : {1'b0, {WIDTH-1{1}}}.
  - ovf still reports 1, and cout is unchanged.
- Segmentation:
  - Segment width SEG = WIDTH/STAGES. Stage k adds bits [k*SEG +: SEG] using the carry registered from stage k-1.
  - Unprocessed operand slices and finished result slices are skewed through registers so that each stage holds exactly one operation.
- Latency:
  - An accepted beat (in_valid && in_ready at edge N) presents out_valid=1 with its result at edge N+STAGES, when no stall occurs.
  - Throughput is one beat per cycle.
- Stall:
  - stall = out_valid && !out_ready.
  - When stall=1, every stage register, including the valid bits, holds its value.
  - in_ready = !stall, a combinational function of out_valid and out_ready only; it does not depend on in_valid.
- Bubbles:
  - Each stage carries a valid bit.
  - A cycle with in_valid=0 and no stall inserts a bubble; bubbles advance like data.
  - out_valid is the last stage's valid bit.
- Output stability: while out_valid=1 and out_ready=0, result/cout/ovf must not change.
- Ordering: results leave in acceptance order; no reordering, drop or duplication.
- Reset:
  - rst=1 at an edge clears all valid bits, result, cout and ovf to 0, and all internal carries to 0.
  - In-flight beats are discarded, including mid-pipeline beats; no partial beat emerges afterwards.
  - in_ready is 1 in the cycle after reset, since out_valid=0.
- Simultaneous events:
  - in_valid and out_ready may both be high with a full pipe; the output beat retires and the new beat enters on the same edge.
  - rst dominates every handshake.
- STAGES=1: a single registered full-width add with latency 1; the same handshake rules apply.
- Wrap-around:
  - SATURATE=0 results are modulo 2^WIDTH.
  - The carry out of the top segment feeds only cout; it is never fed back.
- Sign:
  - a, b and the MSB are interpreted as two's complement for ovf and saturation only.
  - cout is the unsigned carry/borrow.

Test Plan (WIDTH=32, STAGES=4 unless stated):
- Add with cross-segment carry:
  - Stimulus: a=0x0000_FFFF, b=0x0000_0001, sub=0.
  - Response: result=0x0001_0000, cout=0, ovf=0, out_valid exactly 4 cycles after acceptance.
- Subtract with borrow:
  - Stimulus: a=0x0000_0003, b=0x0000_0005, sub=1.
  - Response: result=0xFFFF_FFFE, cout=1, ovf=0.
- Overflow, wrap then saturate:
  - Stimulus: a=0x7FFF_FFFF, b=0x0000_0001, sub=0.
  - Response: SATURATE=0 gives result=0x8000_0000 with ovf=1. SATURATE=1 gives 0x7FFF_FFFF with ovf=1.
  - Negative overflow: a=0x8000_0000, b=1, sub=1 with SATURATE=1 gives 0x8000_0000, ovf=1.
- Backpressure:
  - Stimulus: stream 8 beats (a=i, b=i, alternating sub) with out_ready low for cycles 5-8.
  - Response: in_ready=0 during the stall, outputs held stable, all 8 results in order (a+b=2i, a-b=0), none lost or duplicated.
- Bubbles and full throughput:
  - Stimulus: in_valid pattern 1,0,1,1,0,1 with out_ready=1.
  - Response: the out_valid pattern is the same sequence delayed by 4 cycles.
- Reset mid-operation:
  - Stimulus: 3 beats in flight, then rst=1 for one cycle.
  - Response: out_valid=0 and result/cout/ovf=0 from the next cycle; the 3 beats never appear. The first beat after reset has latency 4.
- STAGES=1 and STAGES=32 regression:
  - Stimulus: a=0xFFFF_FFFF, b=1, sub=0.
  - Response: result=0, cout=1, ovf=0, at latency 1 and 32 respectively.
